// File: rtl/brisc_pkg.sv
// Shared types and widths for the brisc memory subsystem.
// Holds the arbiter state and owner encodings used by mem_arbiter and mem_arb_select.
package brisc_pkg;

    localparam int ADDRESS_WIDTH    = 32;
    localparam int CACHE_LINE_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } mem_arb_state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } mem_arb_owner_e;

endpackage

// File: rtl/mem_arb_select.sv
// Combinational picker that chooses which cache owns the next memory transaction.
// Build option MEM_ARB_ROUND_ROBIN_EN: ties alternate away from the previous owner;
// without it the dcache always wins a tie and no last-owner input exists.
module mem_arb_select
    import brisc_pkg::*;
(
    input  logic           ic_req,
    input  logic           dc_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  mem_arb_owner_e last_owner,
`endif
    output logic           valid,
    output mem_arb_owner_e owner
);

    // A lone requester wins outright; a tie is settled by the build option
    always_comb begin
        valid = ic_req | dc_req;
        owner = DCACHE;
        if (ic_req && !dc_req) begin
            owner = ICACHE;
        end else if (ic_req && dc_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            owner = (last_owner == ICACHE) ? DCACHE : ICACHE;
`else
            owner = DCACHE;
`endif
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single main-memory port between the icache and the dcache.
// One transaction in flight: IDLE picks an owner, ISSUE presents the latched
// request until memory accepts it, WAIT routes the response back to the owner.
// Build option MEM_ARB_ROUND_ROBIN_EN: round-robin tie breaking with a
// last-owner register; otherwise fixed dcache priority.
module mem_arbiter
    import brisc_pkg::*;
#(
    parameter int ADDR_W = ADDRESS_WIDTH,
    parameter int LINE_W = CACHE_LINE_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req_in,
    input  logic [ADDR_W-1:0] ic_req_addr_in,
    output logic              ic_grant_out,
    output logic              ic_fill_out,
    output logic [LINE_W-1:0] ic_fill_data_out,
    output logic [ADDR_W-1:0] ic_fill_addr_out,
    input  logic              dc_req_in,
    input  logic [ADDR_W-1:0] dc_req_addr_in,
    input  logic [LINE_W-1:0] dc_req_data_in,
    input  logic              dc_req_write_in,
    output logic              dc_grant_out,
    output logic              dc_fill_out,
    output logic [LINE_W-1:0] dc_fill_data_out,
    output logic [ADDR_W-1:0] dc_fill_addr_out,
    output logic              mem_req_out,
    output logic [ADDR_W-1:0] mem_req_addr_out,
    output logic [LINE_W-1:0] mem_req_data_out,
    output logic              mem_req_write_out,
    input  logic              mem_ready_in,
    input  logic              mem_resp_in,
    input  logic [LINE_W-1:0] mem_resp_data_in,
    input  logic [ADDR_W-1:0] mem_resp_addr_in
);

    mem_arb_state_e state;
    mem_arb_owner_e owner;
    logic           sel_valid;
    mem_arb_owner_e sel_owner;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    mem_arb_owner_e last_owner;

    // Remember who won the most recent arbitration so the next tie goes the other way
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_owner <= DCACHE;
        end else if (state == IDLE && sel_valid) begin
            last_owner <= sel_owner;
        end
    end
`endif

    mem_arb_select u_select (
        .ic_req     (ic_req_in),
        .dc_req     (dc_req_in),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_owner (last_owner),
`endif
        .valid      (sel_valid),
        .owner      (sel_owner)
    );

    // Transaction FSM: latch the winner's request, hold it until accepted, route the response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            owner             <= DCACHE;
            ic_grant_out      <= 1'b0;
            dc_grant_out      <= 1'b0;
            ic_fill_out       <= 1'b0;
            dc_fill_out       <= 1'b0;
            ic_fill_data_out  <= '0;
            ic_fill_addr_out  <= '0;
            dc_fill_data_out  <= '0;
            dc_fill_addr_out  <= '0;
            mem_req_out       <= 1'b0;
            mem_req_addr_out  <= '0;
            mem_req_data_out  <= '0;
            mem_req_write_out <= 1'b0;
        end else begin
            ic_fill_out <= 1'b0;
            dc_fill_out <= 1'b0;
            case (state)
                IDLE: begin
                    ic_grant_out <= 1'b0;
                    dc_grant_out <= 1'b0;
                    if (sel_valid) begin
                        state       <= ISSUE;
                        owner       <= sel_owner;
                        mem_req_out <= 1'b1;
                        if (sel_owner == ICACHE) begin
                            ic_grant_out      <= 1'b1;
                            mem_req_addr_out  <= ic_req_addr_in;
                            mem_req_data_out  <= '0;
                            mem_req_write_out <= 1'b0;
                        end else begin
                            dc_grant_out      <= 1'b1;
                            mem_req_addr_out  <= dc_req_addr_in;
                            mem_req_data_out  <= dc_req_data_in;
                            mem_req_write_out <= dc_req_write_in;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_ready_in) begin
                        state       <= WAIT;
                        mem_req_out <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_resp_in) begin
                        state <= IDLE;
                        if (mem_req_write_out) begin
                            ic_grant_out <= 1'b0;
                            dc_grant_out <= 1'b0;
                        end else if (owner == ICACHE) begin
                            ic_fill_out      <= 1'b1;
                            ic_fill_data_out <= mem_resp_data_in;
                            ic_fill_addr_out <= mem_resp_addr_in;
                        end else begin
                            dc_fill_out      <= 1'b1;
                            dc_fill_data_out <= mem_resp_data_in;
                            dc_fill_addr_out <= mem_resp_addr_in;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef SYNTHESIS
    // Warn when memory answers while no transaction is waiting; the response is dropped
    always_ff @(posedge clk) begin
        assert (!(reset && mem_resp_in && state != WAIT))
            else $warning("mem_arbiter: mem_resp_in outside WAIT ignored");
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, icache fill, dcache write-back with
// stalls, stray response, tie breaking and reset during WAIT.
// Honours MEM_ARB_ROUND_ROBIN_EN for the tie expectations.
module tb_mem_arbiter;
    import brisc_pkg::*;

    localparam int AW = ADDRESS_WIDTH;
    localparam int LW = CACHE_LINE_WIDTH;

    logic          clk;
    logic          reset;
    logic          ic_req_in;
    logic [AW-1:0] ic_req_addr_in;
    logic          ic_grant_out;
    logic          ic_fill_out;
    logic [LW-1:0] ic_fill_data_out;
    logic [AW-1:0] ic_fill_addr_out;
    logic          dc_req_in;
    logic [AW-1:0] dc_req_addr_in;
    logic [LW-1:0] dc_req_data_in;
    logic          dc_req_write_in;
    logic          dc_grant_out;
    logic          dc_fill_out;
    logic [LW-1:0] dc_fill_data_out;
    logic [AW-1:0] dc_fill_addr_out;
    logic          mem_req_out;
    logic [AW-1:0] mem_req_addr_out;
    logic [LW-1:0] mem_req_data_out;
    logic          mem_req_write_out;
    logic          mem_ready_in;
    logic          mem_resp_in;
    logic [LW-1:0] mem_resp_data_in;
    logic [AW-1:0] mem_resp_addr_in;

    int checks = 0;
    int errors = 0;

    localparam logic [LW-1:0] DATA_AA  = {4{32'hAAAA_AAAA}};
    localparam logic [LW-1:0] DATA_55  = {4{32'h5555_5555}};
    localparam logic [LW-1:0] DATA_TIE = {4{32'h1111_2222}};
    localparam logic [LW-1:0] DATA_RST = {4{32'hDEAD_BEEF}};

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit FIRST_IS_IC = 1'b1;
`else
    localparam bit FIRST_IS_IC = 1'b0;
`endif

    mem_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .ic_req_in         (ic_req_in),
        .ic_req_addr_in    (ic_req_addr_in),
        .ic_grant_out      (ic_grant_out),
        .ic_fill_out       (ic_fill_out),
        .ic_fill_data_out  (ic_fill_data_out),
        .ic_fill_addr_out  (ic_fill_addr_out),
        .dc_req_in         (dc_req_in),
        .dc_req_addr_in    (dc_req_addr_in),
        .dc_req_data_in    (dc_req_data_in),
        .dc_req_write_in   (dc_req_write_in),
        .dc_grant_out      (dc_grant_out),
        .dc_fill_out       (dc_fill_out),
        .dc_fill_data_out  (dc_fill_data_out),
        .dc_fill_addr_out  (dc_fill_addr_out),
        .mem_req_out       (mem_req_out),
        .mem_req_addr_out  (mem_req_addr_out),
        .mem_req_data_out  (mem_req_data_out),
        .mem_req_write_out (mem_req_write_out),
        .mem_ready_in      (mem_ready_in),
        .mem_resp_in       (mem_resp_in),
        .mem_resp_data_in  (mem_resp_data_in),
        .mem_resp_addr_in  (mem_resp_addr_in)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [LW-1:0] observed,
                                input logic [LW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_ctl"}, {ic_grant_out, ic_fill_out, dc_grant_out, dc_fill_out,
                                     mem_req_out, mem_req_write_out}, '0);
        check_output({tag, "_req_addr"}, mem_req_addr_out, '0);
        check_output({tag, "_req_data"}, mem_req_data_out, '0);
        check_output({tag, "_ic_fill"}, {ic_fill_data_out | LW'(ic_fill_addr_out)}, '0);
        check_output({tag, "_dc_fill"}, {dc_fill_data_out | LW'(dc_fill_addr_out)}, '0);
        check_output({tag, "_state"}, LW'(dut.state), LW'(IDLE));
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence
    initial begin
        reset            = 1'b1;
        ic_req_in        = 1'b0;
        ic_req_addr_in   = '0;
        dc_req_in        = 1'b0;
        dc_req_addr_in   = '0;
        dc_req_data_in   = '0;
        dc_req_write_in  = 1'b0;
        mem_ready_in     = 1'b0;
        mem_resp_in      = 1'b0;
        mem_resp_data_in = '0;
        mem_resp_addr_in = '0;

        #2 reset = 1'b0;
        #1;
        check_all_zero("por_async");
        tick();
        check_all_zero("por_edge");
        reset = 1'b1;
        tick();
        check_all_zero("idle_quiet");

        $display("[TB] single icache fill");
        ic_req_in      = 1'b1;
        ic_req_addr_in = 32'h40;
        tick();
        check_output("ic_issue_req", {mem_req_out, ic_grant_out, dc_grant_out, mem_req_write_out}, 4'b1100);
        check_output("ic_issue_addr", mem_req_addr_out, 32'h40);
        mem_ready_in = 1'b1;
        tick();
        mem_ready_in = 1'b0;
        check_output("ic_wait_req", {mem_req_out, ic_grant_out, dc_grant_out}, 3'b010);
        tick();
        mem_resp_in      = 1'b1;
        mem_resp_data_in = DATA_AA;
        mem_resp_addr_in = 32'h40;
        tick();
        mem_resp_in = 1'b0;
        ic_req_in   = 1'b0;
        check_output("ic_fill_pulse", {ic_fill_out, dc_fill_out, ic_grant_out, dc_grant_out}, 4'b1010);
        check_output("ic_fill_data", ic_fill_data_out, DATA_AA);
        check_output("ic_fill_addr", ic_fill_addr_out, 32'h40);
        tick();
        check_output("ic_after_pulse", {ic_fill_out, ic_grant_out, dc_grant_out, mem_req_out}, 4'b0000);
        check_output("ic_fill_hold", ic_fill_data_out, DATA_AA);

        $display("[TB] dcache write-back with stalls");
        dc_req_in       = 1'b1;
        dc_req_write_in = 1'b1;
        dc_req_addr_in  = 32'h80;
        dc_req_data_in  = DATA_55;
        tick();
        for (int s = 0; s < 3; s++) begin
            check_output($sformatf("wb_stall%0d_ctl", s),
                         {mem_req_out, mem_req_write_out, dc_grant_out, ic_grant_out}, 4'b1110);
            check_output($sformatf("wb_stall%0d_data", s), mem_req_data_out, DATA_55);
            check_output($sformatf("wb_stall%0d_addr", s), mem_req_addr_out, 32'h80);
            if (s == 2) mem_ready_in = 1'b1;
            tick();
        end
        mem_ready_in = 1'b0;
        check_output("wb_wait", {mem_req_out, dc_grant_out}, 2'b01);
        mem_resp_in      = 1'b1;
        mem_resp_data_in = DATA_RST;
        mem_resp_addr_in = 32'h80;
        tick();
        mem_resp_in     = 1'b0;
        dc_req_in       = 1'b0;
        dc_req_write_in = 1'b0;
        check_output("wb_done", {dc_fill_out, ic_fill_out, dc_grant_out, ic_grant_out}, 4'b0000);
        check_output("wb_no_fill_data", dc_fill_data_out, '0);

        $display("[TB] stray response in IDLE");
        tick();
        mem_resp_in      = 1'b1;
        mem_resp_data_in = DATA_TIE;
        mem_resp_addr_in = 32'h1234;
        tick();
        mem_resp_in = 1'b0;
        check_output("stray_no_pulse", {ic_fill_out, dc_fill_out, ic_grant_out, dc_grant_out}, 4'b0000);
        check_output("stray_ic_hold", ic_fill_data_out, DATA_AA);
        check_output("stray_state", LW'(dut.state), LW'(IDLE));

        $display("[TB] tie from reset");
        reset = 1'b0;
        #1;
        check_all_zero("mid_async");
        ic_req_in       = 1'b1;
        ic_req_addr_in  = 32'h100;
        dc_req_in       = 1'b1;
        dc_req_addr_in  = 32'h200;
        dc_req_data_in  = '0;
        dc_req_write_in = 1'b0;
        tick();
        check_all_zero("mid_edge");
        reset = 1'b1;
        tick();
        check_output("tie1_grant", {ic_grant_out, dc_grant_out}, {FIRST_IS_IC, !FIRST_IS_IC});
        check_output("tie1_addr", mem_req_addr_out, FIRST_IS_IC ? 32'h100 : 32'h200);
        mem_ready_in = 1'b1;
        tick();
        mem_ready_in     = 1'b0;
        mem_resp_in      = 1'b1;
        mem_resp_data_in = DATA_TIE;
        mem_resp_addr_in = FIRST_IS_IC ? 32'h100 : 32'h200;
        tick();
        mem_resp_in = 1'b0;
        check_output("tie1_fill", {ic_fill_out, dc_fill_out}, {FIRST_IS_IC, !FIRST_IS_IC});
        check_output("tie1_fill_data", FIRST_IS_IC ? ic_fill_data_out : dc_fill_data_out, DATA_TIE);
        tick();
        check_output("tie2_grant", {ic_grant_out, dc_grant_out, mem_req_out}, 3'b011);
        check_output("tie2_addr", mem_req_addr_out, 32'h200);
        check_output("tie2_no_pulse", {ic_fill_out, dc_fill_out}, 2'b00);

        $display("[TB] reset during WAIT");
        mem_ready_in = 1'b1;
        tick();
        mem_ready_in = 1'b0;
        ic_req_in    = 1'b0;
        dc_req_in    = 1'b0;
        check_output("rw_in_wait", LW'(dut.state), LW'(WAIT));
        reset = 1'b0;
        #1;
        check_output("rw_async", {ic_grant_out, dc_grant_out, mem_req_out, dc_fill_out}, 4'b0000);
        tick();
        reset            = 1'b1;
        mem_resp_in      = 1'b1;
        mem_resp_data_in = DATA_RST;
        mem_resp_addr_in = 32'h200;
        tick();
        mem_resp_in = 1'b0;
        check_all_zero("rw_late_resp");
        tick();
        check_all_zero("rw_settled");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
